// File: rtl/seq_imul.sv
// Sequential NUM_BITS x NUM_BITS -> 2*NUM_BITS integer multiplier.
// One shared adder row retires BITS_PER_CYCLE multiplier bits per clock. Signed operands are
// converted to magnitudes on acceptance, multiplied unsigned, and the product is negated once
// at the end when exactly one operand was negative.
module seq_imul #(
    parameter int unsigned NUM_BITS       = 16,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    iStart,
    input  logic                    iSigned,
    input  logic [NUM_BITS-1:0]     iA,
    input  logic [NUM_BITS-1:0]     iB,
    output logic                    oBusy,
    output logic                    oDone,
    output logic [2*NUM_BITS-1:0]   oResult
);

    localparam int unsigned W2    = 2 * NUM_BITS;
    localparam int unsigned STEPS = NUM_BITS / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_BITS < 2) begin : g_bad_width
        $error("seq_imul: NUM_BITS must be at least 2");
    end
    if ((BITS_PER_CYCLE == 0) || (BITS_PER_CYCLE > NUM_BITS) ||
        ((NUM_BITS % BITS_PER_CYCLE) != 0)) begin : g_bad_step
        $error("seq_imul: BITS_PER_CYCLE must be non-zero and divide NUM_BITS");
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [NUM_BITS-1:0] mcand_q,  mcand_d;
    logic [NUM_BITS-1:0] mplier_q, mplier_d;
    logic [W2-1:0]       acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                neg_q,    neg_d;
    logic [W2-1:0]       result_q, result_d;

    // Per-iteration datapath signals.
    logic [W2-1:0]       partial;
    logic [W2-1:0]       sum;
    logic [31:0]         shamt;
    logic                last_step;
    logic                accept;
    logic [NUM_BITS-1:0] a_mag;
    logic [NUM_BITS-1:0] b_mag;

    // Operand magnitudes and the step's shifted partial product.
    always_comb begin
        // -(-2^(N-1)) wraps back to 2^(N-1), which is the correct unsigned magnitude.
        a_mag     = (iSigned && iA[NUM_BITS-1]) ? -iA : iA;
        b_mag     = (iSigned && iB[NUM_BITS-1]) ? -iB : iB;
        shamt     = 32'(cnt_q) * 32'(BITS_PER_CYCLE);
        partial   = (W2'(mcand_q) * W2'(mplier_q[BITS_PER_CYCLE-1:0])) << shamt;
        sum       = acc_q + partial;
        last_step = (cnt_q == CNT_W'(STEPS - 1));
        // A new request is taken in IDLE and also in DONE for back-to-back operation.
        accept    = iStart && ((state_q == StIdle) || (state_q == StDone));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = iSigned && (iA[NUM_BITS-1] ^ iB[NUM_BITS-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end else begin
                    state_d  = StIdle;
                end
            end
            StCalc: begin
                // iStart is deliberately ignored here; operands stay as captured.
                acc_d    = sum;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    result_d = neg_q ? -sum : sum;
                    state_d  = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any in-flight operation.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign oBusy   = (state_q == StCalc);
    assign oDone   = (state_q == StDone);
    assign oResult = result_q;

endmodule

// File: tb/tb_seq_imul.sv
// Self-checking bench for seq_imul (NUM_BITS=8, BITS_PER_CYCLE=2).
module tb_seq_imul;

    localparam int unsigned NB    = 8;
    localparam int unsigned BPC   = 2;
    localparam int unsigned STEPS = NB / BPC;

    logic            Clock   = 1'b0;
    logic            Reset_n = 1'b0;
    logic            iStart  = 1'b0;
    logic            iSigned = 1'b0;
    logic [NB-1:0]   iA      = '0;
    logic [NB-1:0]   iB      = '0;
    logic            oBusy;
    logic            oDone;
    logic [2*NB-1:0] oResult;

    int compared   = 0;
    int mismatched = 0;
    logic [2*NB-1:0] exp_result = '0;

    seq_imul #(
        .NUM_BITS       (NB),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iA      (iA),
        .iB      (iB),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oResult (oResult)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference product from plain integer arithmetic.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
        int sa;
        int sb;
        int p;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        p = sa * sb;
        return p[15:0];
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One multiply from acceptance to the DONE cycle; returns while oDone should be high.
    // With poke set, iStart is pulsed with junk operands throughout CALC.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic poke);
        logic [15:0] prev;
        prev    = exp_result;
        iA      = a;
        iB      = b;
        iSigned = s;
        iStart  = 1'b1;
        tick();
        iStart  = 1'b0;
        iA      = ~a;
        iB      = b ^ 8'h5a;
        iSigned = ~s;
        check("busy_after_accept", 16'(oBusy), 16'd1);
        check("done_after_accept", 16'(oDone), 16'd0);
        check("result_held_in_calc", oResult, prev);
        for (int i = 1; i < int'(STEPS); i++) begin
            if (poke) begin
                iStart  = 1'b1;
                iA      = 8'($urandom);
                iB      = 8'($urandom);
                iSigned = 1'($urandom);
            end
            tick();
            check("busy_in_calc", 16'(oBusy), 16'd1);
            check("done_in_calc", 16'(oDone), 16'd0);
        end
        tick();
        iStart     = 1'b0;
        exp_result = ref_mul(a, b, s);
        check("done_pulse", 16'(oDone), 16'd1);
        check("busy_in_done", 16'(oBusy), 16'd0);
        check("result", oResult, exp_result);
    endtask

    initial begin
        // Reset state.
        #1;
        check("reset_busy", 16'(oBusy), 16'd0);
        check("reset_done", 16'(oDone), 16'd0);
        check("reset_result", oResult, 16'h0000);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // Unsigned full-scale operands.
        run_op(8'd255, 8'd255, 1'b0, 1'b0);
        check("unsigned_ff_ff", oResult, 16'hFE01);
        tick();
        check("done_one_cycle", 16'(oDone), 16'd0);
        check("idle_not_busy", 16'(oBusy), 16'd0);

        // Signed corners, second one back-to-back from the DONE cycle.
        run_op(8'h80, 8'h80, 1'b1, 1'b0);
        check("signed_80_80", oResult, 16'h4000);
        run_op(8'h80, 8'h01, 1'b1, 1'b0);
        check("signed_80_01", oResult, 16'hFF80);

        // Mixed signs in both modes.
        run_op(8'hFD, 8'd7, 1'b1, 1'b0);
        check("signed_fd_07", oResult, 16'hFFEB);
        run_op(8'hFD, 8'd7, 1'b0, 1'b0);
        check("unsigned_fd_07", oResult, 16'h06EB);

        // iStart during CALC is ignored.
        tick();
        run_op(8'd19, 8'hE2, 1'b1, 1'b1);
        check("poke_ignored", oResult, 16'hFDC6);

        // Zero operand still takes the full latency.
        run_op(8'd0, 8'hA7, 1'b1, 1'b0);
        check("zero_operand", oResult, 16'h0000);

        // Hold: operands wiggle with iStart low.
        for (int i = 0; i < 20; i++) begin
            iA      = 8'($urandom);
            iB      = 8'($urandom);
            iSigned = 1'($urandom);
            tick();
            check("hold_done", 16'(oDone), 16'd0);
            check("hold_result", oResult, exp_result);
        end

        // Asynchronous reset mid-CALC.
        iA      = 8'd200;
        iB      = 8'd150;
        iSigned = 1'b0;
        iStart  = 1'b1;
        tick();
        iStart  = 1'b0;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        check("midcalc_reset_busy", 16'(oBusy), 16'd0);
        check("midcalc_reset_done", 16'(oDone), 16'd0);
        check("midcalc_reset_result", oResult, 16'h0000);
        exp_result = '0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        check("post_reset_idle", 16'(oBusy), 16'd0);
        run_op(8'd200, 8'd150, 1'b0, 1'b0);
        check("post_reset_op", oResult, 16'h7530);

        // Randomized operands, modes, pokes and idle gaps.
        for (int n = 0; n < 800; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                check("rand_idle_done", 16'(oDone), 16'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
